// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - two-way set-associative write-back data cache controller
// Two-word blocks, one LRU bit per set, dirty write-back on eviction and halt-triggered flush.
module dcache_ctrl #(
  parameter int SETS = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        halt,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        flushed,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] daddr,
  output logic [31:0] dstore,
  input  logic        dwait,
  input  logic [31:0] dload
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 29 - IDX_W;
  localparam int FR_W   = IDX_W + 1;
  localparam int FRAMES = 2 * SETS;

  typedef enum logic [2:0] {
    IDLE, WB0, WB1, FETCH0, FETCH1, FLUSH0, FLUSH1, FLUSHED
  } state_t;

  state_t            state_q, state_d;
  logic [FR_W-1:0]   cnt_q, cnt_d;
  logic              vic_q, vic_d;
  logic [TAG_W-1:0]  rtag_q, rtag_d;
  logic [IDX_W-1:0]  ridx_q, ridx_d;
  logic [FRAMES-1:0] valid_q, valid_d;
  logic [FRAMES-1:0] dirty_q, dirty_d;
  logic [SETS-1:0]   lru_q, lru_d;

  // A frame index is {set, way}; the flush counter walks frames in that same encoding.
  logic [TAG_W-1:0]  tag_q  [FRAMES];
  logic [31:0]       data_q [FRAMES][2];

  logic              data_we;
  logic [FR_W-1:0]   data_fr;
  logic              data_word;
  logic [31:0]       data_wdata;
  logic              tag_we;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic              req_word;
  logic              hit0, hit1;
  logic [FR_W-1:0]   hit_fr, vic_fr, miss_fr;
  logic              unused_addr_bits;

  assign req_idx  = dmemaddr[IDX_W+2:3];
  assign req_tag  = dmemaddr[31:IDX_W+3];
  assign req_word = dmemaddr[2];
  assign unused_addr_bits = ^dmemaddr[1:0];

  assign hit0    = valid_q[{req_idx, 1'b0}] && (tag_q[{req_idx, 1'b0}] == req_tag);
  assign hit1    = valid_q[{req_idx, 1'b1}] && (tag_q[{req_idx, 1'b1}] == req_tag);
  assign hit_fr  = {req_idx, hit1};
  assign vic_fr  = {req_idx, lru_q[req_idx]};
  assign miss_fr = {ridx_q, vic_q};

  function automatic logic [31:0] blk_addr(input logic [TAG_W-1:0] t,
                                           input logic [IDX_W-1:0] i,
                                           input logic w);
    return {t, i, w, 2'b00};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    vic_d      = vic_q;
    rtag_d     = rtag_q;
    ridx_d     = ridx_q;
    valid_d    = valid_q;
    dirty_d    = dirty_q;
    lru_d      = lru_q;
    dhit       = 1'b0;
    dmemload   = '0;
    flushed    = 1'b0;
    dREN       = 1'b0;
    dWEN       = 1'b0;
    daddr      = '0;
    dstore     = '0;
    data_we    = 1'b0;
    data_fr    = '0;
    data_word  = 1'b0;
    data_wdata = '0;
    tag_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (halt) begin
          state_d = FLUSH0;
          cnt_d   = '0;
        end else if (dmemREN || dmemWEN) begin
          if (hit0 || hit1) begin
            dhit            = 1'b1;
            dmemload        = data_q[hit_fr][req_word];
            lru_d[req_idx]  = ~hit1;
            if (dmemWEN) begin
              data_we         = 1'b1;
              data_fr         = hit_fr;
              data_word       = req_word;
              data_wdata      = dmemstore;
              dirty_d[hit_fr] = 1'b1;
            end
          end else begin
            // Latch the request so memory-side outputs stay stable for the whole miss.
            vic_d   = lru_q[req_idx];
            rtag_d  = req_tag;
            ridx_d  = req_idx;
            state_d = (valid_q[vic_fr] && dirty_q[vic_fr]) ? WB0 : FETCH0;
          end
        end
      end

      WB0: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tag_q[miss_fr], ridx_q, 1'b0);
        dstore = data_q[miss_fr][0];
        if (!dwait) state_d = WB1;
      end

      WB1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tag_q[miss_fr], ridx_q, 1'b1);
        dstore = data_q[miss_fr][1];
        if (!dwait) state_d = FETCH0;
      end

      FETCH0: begin
        dREN  = 1'b1;
        daddr = blk_addr(rtag_q, ridx_q, 1'b0);
        if (!dwait) begin
          data_we    = 1'b1;
          data_fr    = miss_fr;
          data_word  = 1'b0;
          data_wdata = dload;
          state_d    = FETCH1;
        end
      end

      FETCH1: begin
        dREN  = 1'b1;
        daddr = blk_addr(rtag_q, ridx_q, 1'b1);
        if (!dwait) begin
          data_we          = 1'b1;
          data_fr          = miss_fr;
          data_word        = 1'b1;
          data_wdata       = dload;
          tag_we           = 1'b1;
          valid_d[miss_fr] = 1'b1;
          dirty_d[miss_fr] = 1'b0;
          state_d          = IDLE;
        end
      end

      FLUSH0: begin
        if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
          dWEN   = 1'b1;
          daddr  = blk_addr(tag_q[cnt_q], cnt_q[FR_W-1:1], 1'b0);
          dstore = data_q[cnt_q][0];
          if (!dwait) state_d = FLUSH1;
        end else if (cnt_q == {FR_W{1'b1}}) begin
          state_d = FLUSHED;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      FLUSH1: begin
        dWEN   = 1'b1;
        daddr  = blk_addr(tag_q[cnt_q], cnt_q[FR_W-1:1], 1'b1);
        dstore = data_q[cnt_q][1];
        if (!dwait) begin
          dirty_d[cnt_q] = 1'b0;
          if (cnt_q == {FR_W{1'b1}}) begin
            state_d = FLUSHED;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = FLUSH0;
          end
        end
      end

      FLUSHED: flushed = 1'b1;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vic_q   <= 1'b0;
      rtag_q  <= '0;
      ridx_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vic_q   <= vic_d;
      rtag_q  <= rtag_d;
      ridx_q  <= ridx_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      lru_q   <= lru_d;
    end
  end

  // Tag and data storage carry no reset; valid bits gate every use.
  always_ff @(posedge CLK) begin
    if (data_we) data_q[data_fr][data_word] <= data_wdata;
    if (tag_we)  tag_q[miss_fr] <= rtag_q;
  end

endmodule
